// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: Moore FSM that sequences fetch, decode,
// memory, execute, writeback and branch steps, and drives the datapath controls.
module multicycle_controller #(
    parameter logic [3:0] ALU_ADD = 4'b0100,
    parameter logic [3:0] ALU_SUB = 4'b0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        CarryIN,
    output logic        SetFlags,
    output logic        Shift_ctrl,
    output logic        ALUSrcA,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  BL_ctrl,
    output logic [3:0]  ALUControl,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t state_q, state_d;

    logic [1:0] op;
    logic       rd_is_pc;
    logic       cond_pass;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign rd_is_pc     = (Instr[15:12] == 4'hF);
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    // Debug view of the state; held at FETCH's code while reset is asserted.
    assign state = reset ? 4'd0 : state_q;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // ARM condition evaluation on {Z,N,C,V}; 1111 (NV) never passes.
    always_comb begin
        logic z, n, c, v;
        z = ALUFlags[3];
        n = ALUFlags[2];
        c = ALUFlags[1];
        v = ALUFlags[0];
        cond_pass = 1'b0;
        case (Instr[31:28])
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Instruction-derived register/immediate selects, independent of state.
    always_comb begin
        RegSrc[0] = (op == 2'b10);
        RegSrc[1] = (op == 2'b01) && !Instr[20];
        ImmSrc    = (op == 2'b11) ? 2'b00 : op;
    end

    // Next-state and Moore outputs; reset suppresses every control output.
    always_comb begin
        state_d    = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        CarryIN    = 1'b0;
        SetFlags   = 1'b0;
        Shift_ctrl = 1'b0;
        ALUSrcA    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcB    = 2'b00;
        BL_ctrl    = 2'b00;
        ALUControl = 4'b0000;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    IRWrite    = 1'b1;
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = ALU_ADD;
                    ResultSrc  = 2'b10;
                    PCWrite    = 1'b1;
                    state_d    = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = ALU_ADD;
                    ResultSrc  = 2'b10;
                    if (!cond_pass) state_d = S_FETCH;
                    else begin
                        case (op)
                            2'b01:   state_d = S_MEMADR;
                            2'b00:   state_d = Instr[25] ? S_EXECUTEI : S_EXECUTER;
                            2'b10:   state_d = S_BRANCH;
                            default: state_d = S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: begin
                    ALUSrcB    = 2'b01;
                    ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
                    state_d    = Instr[20] ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    AdrSrc  = 1'b1;
                    state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    PCWrite   = rd_is_pc;
                    state_d   = S_FETCH;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_EXECUTER, S_EXECUTEI: begin
                    ALUSrcB    = 2'b11;
                    ALUControl = Instr[24:21];
                    SetFlags   = Instr[20];
                    CarryIN    = ALUFlags[1];
                    Shift_ctrl = (state_q == S_EXECUTEI);
                    state_d    = (Instr[24:23] == 2'b10) ? S_FETCH : S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    PCWrite  = rd_is_pc;
                    state_d  = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcB    = 2'b01;
                    ALUControl = ALU_ADD;
                    ResultSrc  = 2'b10;
                    PCWrite    = 1'b1;
                    if (Instr[24]) begin
                        BL_ctrl  = 2'b11;
                        RegWrite = 1'b1;
                    end
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: per-cycle state and
// control-output vectors, plus instruction latency sequences.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic        CarryIN, SetFlags, Shift_ctrl, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, BL_ctrl;
    logic [3:0]  ALUControl, state;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    multicycle_controller #(.ALU_ADD(4'b0100), .ALU_SUB(4'b0010)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .CarryIN(CarryIN),
        .SetFlags(SetFlags), .Shift_ctrl(Shift_ctrl), .ALUSrcA(ALUSrcA),
        .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .BL_ctrl(BL_ctrl), .ALUControl(ALUControl),
        .state(state)
    );

    always #5 clk = ~clk;

    // Packed order: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,CarryIN,SetFlags,
    //   Shift_ctrl,ALUSrcA,ResultSrc,ALUSrcB,ImmSrc,RegSrc,BL_ctrl,ALUControl}
    localparam logic [22:0] ALLMASK = '1;
    localparam logic [22:0] ENMASK  = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [3:0]  flags;
        logic [3:0]  st;
        logic [22:0] exp;
        logic [22:0] mask;
    } vec_t;

    vec_t vecs[$];

    // is = {ImmSrc, RegSrc} expected for the instruction in that row
    function automatic logic [22:0] e_fetch(logic [3:0] is);
        return {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 2'b10, is, 2'b00, 4'b0100};
    endfunction
    function automatic logic [22:0] e_dec(logic [3:0] is);
        return {8'b0, 1'b1, 2'b10, 2'b10, is, 2'b00, 4'b0100};
    endfunction
    function automatic logic [22:0] e_madr(logic [3:0] is, logic [3:0] alu);
        return {9'b0, 2'b00, 2'b01, is, 2'b00, alu};
    endfunction
    function automatic logic [22:0] e_mread(logic [3:0] is);
        return {1'b0,1'b1,7'b0, 2'b00, 2'b00, is, 2'b00, 4'b0000};
    endfunction
    function automatic logic [22:0] e_mwb(logic [3:0] is, logic pcw);
        return {pcw,1'b0,1'b0,1'b0,1'b1,4'b0, 2'b01, 2'b00, is, 2'b00, 4'b0000};
    endfunction
    function automatic logic [22:0] e_mwr(logic [3:0] is);
        return {1'b0,1'b1,1'b1,6'b0, 2'b00, 2'b00, is, 2'b00, 4'b0000};
    endfunction
    function automatic logic [22:0] e_exec(logic [3:0] is, logic cin, logic sf, logic sh, logic [3:0] alu);
        return {5'b0, cin, sf, sh, 1'b0, 2'b00, 2'b11, is, 2'b00, alu};
    endfunction
    function automatic logic [22:0] e_awb(logic [3:0] is, logic pcw);
        return {pcw,1'b0,1'b0,1'b0,1'b1,4'b0, 2'b00, 2'b00, is, 2'b00, 4'b0000};
    endfunction
    function automatic logic [22:0] e_br(logic [3:0] is, logic l);
        return {1'b1,1'b0,1'b0,1'b0,l,4'b0, 2'b10, 2'b01, is, {l,l}, 4'b0100};
    endfunction

    function automatic vec_t row(logic r, logic [31:0] i, logic [3:0] f, logic [3:0] s,
                                 logic [22:0] e, logic [22:0] m);
        vec_t t;
        t.rst = r; t.instr = i; t.flags = f; t.st = s; t.exp = e; t.mask = m;
        return t;
    endfunction

    localparam logic [31:0] ADDI  = 32'hE2811005;  // ADD R1,R1,#5
    localparam logic [31:0] LDR   = 32'hE5902004;  // LDR R2,[R0,#4]
    localparam logic [31:0] LDRPC = 32'hE511F004;  // LDR PC,[R1,#-4]
    localparam logic [31:0] STR   = 32'hE5812000;  // STR R2,[R1]
    localparam logic [31:0] BL    = 32'hEB000002;
    localparam logic [31:0] BEQ   = 32'h0A000004;
    localparam logic [31:0] BNV   = 32'hFA000000;  // condition 1111
    localparam logic [31:0] CDP   = 32'hEE000000;  // Op=11
    localparam logic [31:0] ADDPC = 32'hE08FF001;  // ADD PC,PC,R1
    localparam logic [31:0] CMP   = 32'hE1510002;  // CMP R1,R2
    localparam logic [31:0] ADDGT = 32'hC2811005;

    task automatic check_row(input int unsigned idx, input vec_t v);
        logic [22:0] got;
        got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, CarryIN, SetFlags,
               Shift_ctrl, ALUSrcA, ResultSrc, ALUSrcB, ImmSrc, RegSrc, BL_ctrl, ALUControl};
        n_cmp++;
        if (state !== v.st) begin
            n_bad++;
            $display("FAIL row%0d state: got %0d want %0d", idx, state, v.st);
        end
        n_cmp++;
        if ((got & v.mask) !== (v.exp & v.mask)) begin
            n_bad++;
            $display("FAIL row%0d outputs: got %06h want %06h (mask %06h)", idx, got, v.exp, v.mask);
        end
    endtask

    task automatic latency(input string name, input logic [31:0] ins, input logic [3:0] fl,
                           input int unsigned want);
        int unsigned cyc;
        bit done;
        @(negedge clk);
        reset = 1'b1; Instr = ins; ALUFlags = fl;
        @(negedge clk);
        reset = 1'b0;
        #1;
        cyc = 1; done = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            @(negedge clk);
            #1;
            if (state == 4'd0) done = 1'b1;
            else cyc++;
        end
        n_cmp++;
        if (!done || cyc != want) begin
            n_bad++;
            $display("FAIL latency %s: got %0d (returned=%0d) want %0d", name, cyc, done, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; Instr = ADDI; ALUFlags = 4'b0000;

        vecs.push_back(row(1, ADDI, 4'b0000, 4'd0, 23'h0, ENMASK));
        vecs.push_back(row(1, ADDI, 4'b0000, 4'd0, 23'h0, ENMASK));
        // ADD immediate: 0,1,7,8
        vecs.push_back(row(0, ADDI, 4'b0000, 4'd0, e_fetch(4'b0000), ALLMASK));
        vecs.push_back(row(0, ADDI, 4'b0000, 4'd1, e_dec(4'b0000), ALLMASK));
        vecs.push_back(row(0, ADDI, 4'b0000, 4'd7, e_exec(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100), ALLMASK));
        vecs.push_back(row(0, ADDI, 4'b0000, 4'd8, e_awb(4'b0000, 1'b0), ALLMASK));
        // LDR, positive offset: 0,1,2,3,4
        vecs.push_back(row(0, LDR, 4'b0000, 4'd0, e_fetch(4'b0100), ALLMASK));
        vecs.push_back(row(0, LDR, 4'b0000, 4'd1, e_dec(4'b0100), ALLMASK));
        vecs.push_back(row(0, LDR, 4'b0000, 4'd2, e_madr(4'b0100, 4'b0100), ALLMASK));
        vecs.push_back(row(0, LDR, 4'b0000, 4'd3, e_mread(4'b0100), ALLMASK));
        vecs.push_back(row(0, LDR, 4'b0000, 4'd4, e_mwb(4'b0100, 1'b0), ALLMASK));
        // LDR into PC, negative offset
        vecs.push_back(row(0, LDRPC, 4'b0000, 4'd0, e_fetch(4'b0100), ALLMASK));
        vecs.push_back(row(0, LDRPC, 4'b0000, 4'd1, e_dec(4'b0100), ALLMASK));
        vecs.push_back(row(0, LDRPC, 4'b0000, 4'd2, e_madr(4'b0100, 4'b0010), ALLMASK));
        vecs.push_back(row(0, LDRPC, 4'b0000, 4'd3, e_mread(4'b0100), ALLMASK));
        vecs.push_back(row(0, LDRPC, 4'b0000, 4'd4, e_mwb(4'b0100, 1'b1), ALLMASK));
        // STR: 0,1,2,5
        vecs.push_back(row(0, STR, 4'b0000, 4'd0, e_fetch(4'b0110), ALLMASK));
        vecs.push_back(row(0, STR, 4'b0000, 4'd1, e_dec(4'b0110), ALLMASK));
        vecs.push_back(row(0, STR, 4'b0000, 4'd2, e_madr(4'b0110, 4'b0100), ALLMASK));
        vecs.push_back(row(0, STR, 4'b0000, 4'd5, e_mwr(4'b0110), ALLMASK));
        // BL: 0,1,9
        vecs.push_back(row(0, BL, 4'b0000, 4'd0, e_fetch(4'b1001), ALLMASK));
        vecs.push_back(row(0, BL, 4'b0000, 4'd1, e_dec(4'b1001), ALLMASK));
        vecs.push_back(row(0, BL, 4'b0000, 4'd9, e_br(4'b1001, 1'b1), ALLMASK));
        // BEQ with Z=0 fails, with Z=1 branches
        vecs.push_back(row(0, BEQ, 4'b0000, 4'd0, e_fetch(4'b1001), ALLMASK));
        vecs.push_back(row(0, BEQ, 4'b0000, 4'd1, e_dec(4'b1001), ALLMASK));
        vecs.push_back(row(0, BEQ, 4'b1000, 4'd0, e_fetch(4'b1001), ALLMASK));
        vecs.push_back(row(0, BEQ, 4'b1000, 4'd1, e_dec(4'b1001), ALLMASK));
        vecs.push_back(row(0, BEQ, 4'b1000, 4'd9, e_br(4'b1001, 1'b0), ALLMASK));
        // condition 1111 never passes; Op=11 returns to FETCH
        vecs.push_back(row(0, BNV, 4'b1000, 4'd0, e_fetch(4'b1001), ALLMASK));
        vecs.push_back(row(0, BNV, 4'b1000, 4'd1, e_dec(4'b1001), ALLMASK));
        vecs.push_back(row(0, CDP, 4'b0000, 4'd0, e_fetch(4'b0000), ALLMASK));
        vecs.push_back(row(0, CDP, 4'b0000, 4'd1, e_dec(4'b0000), ALLMASK));
        // ADD PC,PC,R1 with C=1: register path, carry-in, PC write in ALUWB
        vecs.push_back(row(0, ADDPC, 4'b0010, 4'd0, e_fetch(4'b0000), ALLMASK));
        vecs.push_back(row(0, ADDPC, 4'b0010, 4'd1, e_dec(4'b0000), ALLMASK));
        vecs.push_back(row(0, ADDPC, 4'b0010, 4'd6, e_exec(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0100), ALLMASK));
        vecs.push_back(row(0, ADDPC, 4'b0010, 4'd8, e_awb(4'b0000, 1'b1), ALLMASK));
        // CMP: no writeback
        vecs.push_back(row(0, CMP, 4'b0010, 4'd0, e_fetch(4'b0000), ALLMASK));
        vecs.push_back(row(0, CMP, 4'b0010, 4'd1, e_dec(4'b0000), ALLMASK));
        vecs.push_back(row(0, CMP, 4'b0010, 4'd6, e_exec(4'b0000, 1'b1, 1'b1, 1'b0, 4'b1010), ALLMASK));
        vecs.push_back(row(0, CMP, 4'b0010, 4'd0, e_fetch(4'b0000), ALLMASK));
        // CMP again, reset arrives while in EXECUTER
        vecs.push_back(row(0, CMP, 4'b0010, 4'd1, e_dec(4'b0000), ALLMASK));
        vecs.push_back(row(1, CMP, 4'b0010, 4'd0, 23'h0, ENMASK));
        vecs.push_back(row(0, CMP, 4'b0010, 4'd0, e_fetch(4'b0000), ALLMASK));
        // ADDGT: passes with N=V=1, Z=0; fails with Z=1
        vecs.push_back(row(0, ADDGT, 4'b0101, 4'd1, e_dec(4'b0000), ALLMASK));
        vecs.push_back(row(0, ADDGT, 4'b0101, 4'd7, e_exec(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100), ALLMASK));
        vecs.push_back(row(0, ADDGT, 4'b0101, 4'd8, e_awb(4'b0000, 1'b0), ALLMASK));
        vecs.push_back(row(0, ADDGT, 4'b1000, 4'd0, e_fetch(4'b0000), ALLMASK));
        vecs.push_back(row(0, ADDGT, 4'b1000, 4'd1, e_dec(4'b0000), ALLMASK));
        vecs.push_back(row(0, ADDGT, 4'b1000, 4'd0, e_fetch(4'b0000), ALLMASK));

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; Instr = vecs[i].instr; ALUFlags = vecs[i].flags;
            #1;
            check_row(i, vecs[i]);
        end

        latency("branch",    BL,    4'b0000, 3);
        latency("dp_wb",     ADDI,  4'b0000, 4);
        latency("compare",   CMP,   4'b0000, 3);
        latency("load",      LDR,   4'b0000, 5);
        latency("store",     STR,   4'b0000, 4);
        latency("cond_fail", BEQ,   4'b0000, 2);
        latency("hi_fail",   32'h82811005, 4'b1010, 2);  // HI with C=1,Z=1
        latency("ls_pass",   32'h92811005, 4'b1010, 4);  // LS with C=1,Z=1

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALU_ADD, default 4'b0100, the ALUControl code for addition.
REQ-002 SHALL have parameter ALU_SUB, default 4'b0010, the ALUControl code for subtraction.
REQ-003 SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Instr  in  32  instruction register contents.
- ALUFlags  in  4  registered flags {Z,N,C,V}; [3]=Z, [0]=V.
- PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath write enables and address select.
- CarryIN, SetFlags, Shift_ctrl, ALUSrcA  out  1 each  ALU carry-in, flag-register enable, immediate-rotate path select, SrcA select.
- ResultSrc, ALUSrcB, ImmSrc, RegSrc, BL_ctrl  out  2 each  datapath mux selects.
- ALUControl  out  4  ALU operation code.
- state  out  4  current FSM state, for debug.

Function
REQ-004 SHALL be a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH on the next edge with all enables 0.
REQ-005 SHALL drive every output bit not listed for the current state to 0.
REQ-006 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ALU_ADD, ResultSrc=10 and PCWrite=1, then go to DECODE.
REQ-007 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ALUControl=ALU_ADD and ResultSrc=10.
REQ-008 DECODE SHALL evaluate Instr[31:28] against ALUFlags using standard ARM conditions (EQ..LE, AL=1110); code 1111 SHALL count as fail.
REQ-009 From DECODE, a condition fail SHALL go to FETCH with no write; otherwise Op=Instr[27:26] SHALL select the next state: 01->MEMADR, 00 with Instr[25]=0->EXECUTER, 00 with Instr[25]=1->EXECUTEI, 10->BRANCH, 11->FETCH.
REQ-010 RegSrc and ImmSrc SHALL be combinational from Instr in every state:
- RegSrc[0]=1 iff Op=10.
- RegSrc[1]=1 iff Op=01 and Instr[20]=0.
- ImmSrc=Op for Op in {00,01,10}; ImmSrc=00 for Op=11.
REQ-011 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, and ALUControl=ALU_ADD if Instr[23]=1, else ALU_SUB; it SHALL go to MEMREAD if Instr[20]=1, else MEMWRITE.
REQ-012 MEMREAD SHALL drive AdrSrc=1 and ResultSrc=00, then go to MEMWB.
REQ-013 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, plus PCWrite=1 when Instr[15:12]=15, then go to FETCH.
REQ-014 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00 and MemWrite=1, then go to FETCH.
REQ-015 EXECUTER and EXECUTEI SHALL drive:
- ALUSrcA=0, ALUSrcB=11, ALUControl=Instr[24:21], SetFlags=Instr[20], CarryIN=ALUFlags[1].
- Shift_ctrl=0 in EXECUTER, 1 in EXECUTEI.
REQ-016 From EXECUTER/EXECUTEI, the FSM SHALL go to FETCH when Instr[24:23]=10 (TST/TEQ/CMP/CMN, no writeback), else to ALUWB.
REQ-017 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, plus PCWrite=1 when Instr[15:12]=15, then go to FETCH.
REQ-018 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ALUControl=ALU_ADD, ResultSrc=10 and PCWrite=1; if Instr[24]=1 it SHALL also drive BL_ctrl=11 and RegWrite=1 (PC to R14); it SHALL then go to FETCH.
REQ-019 Cycle latency SHALL be: branch 3; data-processing with writeback 4; compare 3; load 5; store 4; condition-fail 2.

Reset
REQ-020 While reset=1, the FSM SHALL load FETCH on each rising edge and SHALL force PCWrite, IRWrite, MemWrite, RegWrite and SetFlags to 0, with state output 0.
REQ-021 Reset asserted in any state, including mid-instruction, SHALL abort that instruction with no further write enables; the first cycle after deassertion SHALL be FETCH.

Verification
REQ-022 Instr=E2811005 (ADD R1,R1,#5) -> states 0,1,7,8,0; in state 7 ALUControl=0100, Shift_ctrl=1, SetFlags=0; in state 8 RegWrite=1.
REQ-023 Instr=E5902004 (LDR) -> states 0,1,2,3,4,0; in state 2 ALUControl=0100, ImmSrc=01; in state 3 AdrSrc=1; in state 4 ResultSrc=01, RegWrite=1.
REQ-024 Instr=EB000002 (BL) -> states 0,1,9,0; in state 9 BL_ctrl=11, RegWrite=1, PCWrite=1, ImmSrc=10, RegSrc[0]=1.
REQ-025 Instr=0A000004 (BEQ) with ALUFlags=0000 -> states 0,1,0 with no PCWrite in state 1; with ALUFlags=1000 -> state 9 is reached.
REQ-026 Instr=E1510002 (CMP) -> states 0,1,6,0 with SetFlags=1 in state 6 and no RegWrite; reset asserted in state 6 -> state 0 on the next edge with all enables 0.
